// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR sequence controller: FSM state encoding,
// the all-ones seed constant and the channel-index width.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_SAVE = 2'd3
  } lfsr_state_e;

  // Low 'width' bits set; callers truncate to their word width.
  function automatic logic [63:0] all_ones(input int width);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < 64; i++) begin
      v[i] = (i < width) ? 1'b1 : 1'b0;
    end
    return v;
  endfunction

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/lfsr_rr_arb.sv
// Round-robin picker: grants the first requester at or after ptr_i, wrapping,
// and reports the grant both one-hot and as an index.
module lfsr_rr_arb
  import lfsr_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o
);

  // Scan priority slots from ptr_i upward; first hit wins.
  always_comb begin
    int   sum;
    int   k;
    logic found;
    logic hit;
    sum   = 0;
    k     = 0;
    found = 1'b0;
    hit   = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = int'(ptr_i) + i;
      k   = (sum >= NUM_CH) ? (sum - NUM_CH) : sum;
      for (int j = 0; j < NUM_CH; j++) begin
        hit      = !found && req_i[j] && (k == j);
        gnt_o[j] = gnt_o[j] | hit;
        idx_o    = hit ? IDX_W'(j) : idx_o;
        found    = found | hit;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Time-shares one galois_lfsr between NUM_CH round-robin requesters, saving and
// restoring per-channel state. Optional zero-word checker: LFSR_SEQ_ZERO_CHK_EN.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_CH    = 4,
  parameter int LEN_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH*LEN_W-1:0]    req_len,
  output logic [NUM_CH-1:0]          gnt,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_CH)-1:0]  cfg_ch,
  input  logic [BIT_WIDTH-1:0]       cfg_seed,
  output logic                       out_vld,
  output logic [BIT_WIDTH-1:0]       out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  output logic                       out_last,
  output logic                       busy,
  output logic [NUM_CH-1:0]          wrap,
`ifdef LFSR_SEQ_ZERO_CHK_EN
  output logic                       zero_err,
`endif
  output logic                       lfsr_enable,
  output logic                       lfsr_load_evt,
  output logic [BIT_WIDTH-1:0]       lfsr_seed_data,
  input  logic                       lfsr_vld,
  input  logic [BIT_WIDTH-1:0]       lfsr_data,
  input  logic                       lfsr_done
);

  localparam int CH_W = ch_idx_w(NUM_CH);
  localparam logic [BIT_WIDTH-1:0] SEED_ONES = BIT_WIDTH'(all_ones(BIT_WIDTH));

  lfsr_state_e            state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [CH_W-1:0]        rr_q, rr_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic                   dirty_q, dirty_d;
  logic [NUM_CH-1:0]      gnt_q, gnt_d;
  logic                   out_vld_q, out_vld_d;
  logic                   out_last_q, out_last_d;
  logic [BIT_WIDTH-1:0]   out_data_q, out_data_d;
  logic [CH_W-1:0]        out_ch_q, out_ch_d;
  logic [NUM_CH-1:0]      wrap_q, wrap_d;
  logic [BIT_WIDTH-1:0]   ctx_q [NUM_CH];
  logic [BIT_WIDTH-1:0]   ctx_d [NUM_CH];

  logic [NUM_CH-1:0]      arb_gnt_s;
  logic [CH_W-1:0]        arb_idx_s;
  logic                   arb_any_s;
  logic [LEN_W-1:0]       len_sel_s;
  logic [BIT_WIDTH-1:0]   seed_sel_s;
  logic [BIT_WIDTH-1:0]   cfg_val_s;
  logic                   run_en_s;
  logic                   beat_s;

  lfsr_rr_arb #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CH_W)
  ) u_arb (
    .req_i  (req),
    .ptr_i  (rr_q),
    .gnt_o  (arb_gnt_s),
    .idx_o  (arb_idx_s),
    .any_o  (arb_any_s)
  );

  // Select the granted channel's length and the active channel's saved seed.
  always_comb begin
    len_sel_s  = '0;
    seed_sel_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      len_sel_s  = (arb_idx_s == CH_W'(i)) ? req_len[i*LEN_W +: LEN_W] : len_sel_s;
      seed_sel_s = (ch_q == CH_W'(i)) ? ctx_q[i] : seed_sel_s;
    end
  end

  // Enable drops combinationally once the last word has been accepted.
  assign run_en_s  = (state_q == ST_RUN) && (cnt_q != '0);
  assign beat_s    = run_en_s && lfsr_vld;
  assign cfg_val_s = (cfg_seed == '0) ? SEED_ONES : cfg_seed;

  // Burst FSM next-state and registered-output staging.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    dirty_d    = dirty_q;
    gnt_d      = '0;
    out_vld_d  = 1'b0;
    out_last_d = 1'b0;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    case (state_q)
      ST_IDLE: begin
        dirty_d = 1'b0;
        if (arb_any_s) begin
          gnt_d = arb_gnt_s;
          ch_d  = arb_idx_s;
          cnt_d = len_sel_s;
          rr_d  = (arb_idx_s == CH_W'(NUM_CH - 1)) ? '0 : (arb_idx_s + CH_W'(1));
          if (len_sel_s == '0) begin
            // Empty burst: one SAVE cycle with the save suppressed, so the
            // registered grant is seen while busy and no re-grant can follow.
            dirty_d = 1'b1;
            state_d = ST_SAVE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (beat_s) begin
          out_vld_d  = 1'b1;
          out_data_d = lfsr_data;
          out_ch_d   = ch_q;
          cnt_d      = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            out_last_d = 1'b1;
            state_d    = ST_SAVE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SAVE: begin
        dirty_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (cfg_we && (cfg_ch == ch_q) && ((state_q == ST_LOAD) || (state_q == ST_RUN))) begin
      dirty_d = 1'b1;
    end else begin
      dirty_d = dirty_d;
    end
  end

  // Context and wrap update; a cfg write overrides the save and clears wrap.
  always_comb begin
    ctx_d  = ctx_q;
    wrap_d = wrap_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((state_q == ST_SAVE) && !dirty_q && (ch_q == CH_W'(i))) begin
        ctx_d[i] = out_data_q;
      end else begin
        ctx_d[i] = ctx_d[i];
      end
      if ((state_q == ST_RUN) && lfsr_done && (ch_q == CH_W'(i))) begin
        wrap_d[i] = 1'b1;
      end else begin
        wrap_d[i] = wrap_d[i];
      end
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        ctx_d[i]  = cfg_val_s;
        wrap_d[i] = 1'b0;
      end else begin
        ctx_d[i]  = ctx_d[i];
      end
    end
  end

  // State, context and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      dirty_q    <= 1'b0;
      gnt_q      <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      wrap_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ctx_q[i] <= SEED_ONES;
      end
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      dirty_q    <= dirty_d;
      gnt_q      <= gnt_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      wrap_q     <= wrap_d;
      ctx_q      <= ctx_d;
    end
  end

`ifdef LFSR_SEQ_ZERO_CHK_EN
  logic zero_err_q;

  // Sticky flag for an all-zero word seen during a burst; the word still goes out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_err_q <= 1'b0;
    end else begin
      zero_err_q <= zero_err_q | (beat_s && (lfsr_data == '0));
    end
  end

  assign zero_err = zero_err_q;
`endif

  assign gnt            = gnt_q;
  assign out_vld        = out_vld_q;
  assign out_data       = out_data_q;
  assign out_ch         = out_ch_q;
  assign out_last       = out_last_q;
  assign busy           = (state_q != ST_IDLE);
  assign wrap           = wrap_q;
  assign lfsr_enable    = run_en_s;
  assign lfsr_load_evt  = (state_q == ST_LOAD);
  assign lfsr_seed_data = (state_q == ST_LOAD) ? seed_sel_s : '0;

endmodule
